regfile_scoreboard: RTL

//   Parametrised successor of the core's integer register file. Provides 2 combinational read ports and 1 write port,

---
 rtl/regfile_scoreboard.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file: 2 combinational read ports, 1 write port,
// optional write bypass, per-register pending scoreboard, RAM-friendly init.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   init_busy        high while the init engine zeroes the array
//   reg_write/rd_*   writeback port (x0 writes discarded)
//   rs1_*/rs2_*      read ports: data and pending (combinational)
//   alloc_valid/addr decode marks a destination as pending
//   flush            clears every pending bit
//   any_pending      OR of the registered pending bits
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            init_busy,
  input  logic            reg_write,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_pending,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_pending,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_addr,
  input  logic            flush,
  output logic            any_pending
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  localparam bit BYP = (BYPASS != 0);

  // Array has no reset so it can map onto RAM.
  logic [XLEN-1:0]  mem_q [NREGS];

  logic [AW-1:0]    cnt_q, cnt_d;
  logic             init_busy_q, init_busy_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic             any_pending_q, any_pending_d;

  logic             wr_ok;
  logic             alloc_ok;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [XLEN-1:0]  mem_wdata;
  logic             byp1;
  logic             byp2;

  always_comb begin
    wr_ok    = reg_write && (rd_addr != '0)
             && !init_busy_q;
    alloc_ok = alloc_valid && (alloc_addr != '0)
             && !init_busy_q;
  end

  // Init engine: one entry per cycle, drops busy
  // on the same edge that clears the last entry.
  always_comb begin
    cnt_d       = cnt_q;
    init_busy_d = init_busy_q;
    if (init_busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        init_busy_d = 1'b0;
      end
    end
  end

  // Single RAM write port shared by init and writeback.
  always_comb begin
    mem_we    = wr_ok;
    mem_waddr = rd_addr;
    mem_wdata = rd_data;
    if (init_busy_q) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end
  end

  // Ordering: flush clear, write clear, alloc set.
  always_comb begin
    pend_d = pend_q;
    if (!init_busy_q) begin
      if (flush) begin
        pend_d = '0;
      end
      if (wr_ok) begin
        pend_d[rd_addr] = 1'b0;
      end
      if (alloc_ok) begin
        pend_d[alloc_addr] = 1'b1;
      end
    end
    pend_d[0]     = 1'b0;
    any_pending_d = |pend_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      init_busy_q   <= 1'b1;
      pend_q        <= '0;
      any_pending_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      init_busy_q   <= init_busy_d;
      pend_q        <= pend_d;
      any_pending_q <= any_pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    byp1 = BYP && reg_write
         && (rd_addr == rs1_addr);
    rs1_data = mem_q[rs1_addr];
    if (byp1) begin
      rs1_data = rd_data;
    end
    if (init_busy_q || (rs1_addr == '0)) begin
      rs1_data = '0;
    end
    rs1_pending = pend_q[rs1_addr] && !byp1
                && !init_busy_q;
  end

  always_comb begin
    byp2 = BYP && reg_write
         && (rd_addr == rs2_addr);
    rs2_data = mem_q[rs2_addr];
    if (byp2) begin
      rs2_data = rd_data;
    end
    if (init_busy_q || (rs2_addr == '0)) begin
      rs2_data = '0;
    end
    rs2_pending = pend_q[rs2_addr] && !byp2
                && !init_busy_q;
  end

  assign init_busy   = init_busy_q;
  assign any_pending = any_pending_q;

endmodule
